charram_writer: RTL and testbench

Write-side controller for the 64×64 character-map RAMs (char code, foreground colour, background colour) read by the video character generator. It owns the single shared write port of those three RAMs. It arbitrates between CPU single-byte writes and a hardware fill engine that clears or paints a row range with a constant character and colour pair. The video read path uses the other RAM port and is not affected.

---
 rtl/charram_pkg.sv | 24 ++
 rtl/charram_writer_if.sv | 56 +++++
 rtl/charram_fill_addr.sv | 60 ++++++
 rtl/charram_writer.sv | 142 ++++++++++++++
 tb/tb_charram_writer.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/charram_pkg.sv
// Shared geometry, RAM-select indices and FSM state type for the character-map RAM writer.
package charram_pkg;
    localparam int ROW_W    = 6;
    localparam int COL_W    = 6;
    localparam int ADDR_W   = ROW_W + COL_W;

    localparam int SEL_CHAR = 0;
    localparam int SEL_FG   = 1;
    localparam int SEL_BG   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef logic [ROW_W-1:0]  row_t;
    typedef logic [COL_W-1:0]  col_t;
    typedef logic [ADDR_W-1:0] addr_t;

    function automatic addr_t mk_addr(input row_t row, input col_t col);
        return {row, col};
    endfunction
endpackage

// File: rtl/charram_writer_if.sv
// Signal bundle between the CPU/fill requesters and the character-map RAM writer.
// CHARRAM_COLRANGE_EN adds the fill column-range inputs.
interface charram_writer_if;
    import charram_pkg::*;

    logic       cpu_req;
    logic [2:0] cpu_sel;
    addr_t      cpu_addr;
    logic [7:0] cpu_data;
    logic       cpu_ack;

    logic       fill_start;
    logic       fill_abort;
    logic [2:0] fill_mask;
    row_t       fill_row_start;
    row_t       fill_row_end;
`ifdef CHARRAM_COLRANGE_EN
    col_t       fill_col_start;
    col_t       fill_col_end;
`endif
    logic [7:0] fill_char;
    logic [7:0] fill_fg;
    logic [7:0] fill_bg;

    addr_t      wr_addr;
    logic       chram_wr;
    logic       fgcol_wr;
    logic       bgcol_wr;
    logic [7:0] chram_wdata;
    logic [7:0] fgcol_wdata;
    logic [7:0] bgcol_wdata;
    logic       busy;
    logic       done;

    modport slave (
        input  cpu_req, cpu_sel, cpu_addr, cpu_data,
        input  fill_start, fill_abort, fill_mask, fill_row_start, fill_row_end,
`ifdef CHARRAM_COLRANGE_EN
        input  fill_col_start, fill_col_end,
`endif
        input  fill_char, fill_fg, fill_bg,
        output cpu_ack, wr_addr, chram_wr, fgcol_wr, bgcol_wr,
        output chram_wdata, fgcol_wdata, bgcol_wdata, busy, done
    );

    modport master (
        output cpu_req, cpu_sel, cpu_addr, cpu_data,
        output fill_start, fill_abort, fill_mask, fill_row_start, fill_row_end,
`ifdef CHARRAM_COLRANGE_EN
        output fill_col_start, fill_col_end,
`endif
        output fill_char, fill_fg, fill_bg,
        input  cpu_ack, wr_addr, chram_wr, fgcol_wr, bgcol_wr,
        input  chram_wdata, fgcol_wdata, bgcol_wdata, busy, done
    );
endinterface

// File: rtl/charram_fill_addr.sv
// Fill-engine cell walker: loads the start corner, steps column-first, flags the final cell.
// Position outputs see through a load so the start cycle can already issue the first write.
module charram_fill_addr
    import charram_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  load_i,
    input  logic  advance_i,
    input  row_t  row_start_i,
    input  row_t  row_end_i,
    input  col_t  col_start_i,
    input  col_t  col_end_i,
    output addr_t addr_o,
    output logic  last_o
);
    row_t row_q, row_d, row_end_q, row_cur, row_end_cur;
    col_t col_q, col_d, col_start_q, col_end_q, col_cur, col_start_cur, col_end_cur;
    logic col_wrap;

    always_comb begin
        row_cur       = load_i ? row_start_i : row_q;
        col_cur       = load_i ? col_start_i : col_q;
        row_end_cur   = load_i ? row_end_i   : row_end_q;
        col_start_cur = load_i ? col_start_i : col_start_q;
        col_end_cur   = load_i ? col_end_i   : col_end_q;
        col_wrap      = (col_cur == col_end_cur);
        row_d         = row_cur;
        col_d         = col_cur;
        if (advance_i) begin
            if (col_wrap) begin
                col_d = col_start_cur;
                row_d = row_cur + 1'b1;
            end else begin
                col_d = col_cur + 1'b1;
            end
        end
    end

    assign addr_o = mk_addr(row_cur, col_cur);
    assign last_o = col_wrap && (row_cur == row_end_cur);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            row_q       <= '0;
            col_q       <= '0;
            row_end_q   <= '0;
            col_start_q <= '0;
            col_end_q   <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
            if (load_i) begin
                row_end_q   <= row_end_i;
                col_start_q <= col_start_i;
                col_end_q   <= col_end_i;
            end
        end
    end
endmodule

// File: rtl/charram_writer.sv
// Shared write port of the char/fg/bg maps: CPU byte writes (1-cycle latency, req held to ack, max 1 per 2 cycles) beat a row-range fill engine.
// All outputs registered; CHARRAM_COLRANGE_EN adds a fill column range, otherwise whole rows are filled.
module charram_writer
    import charram_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    charram_writer_if.slave bus
);
    state_e     state_q, state_d;
    logic [2:0] mask_q;
    logic [7:0] char_q, fg_q, bg_q;
    logic       last_wr_q, last_wr_d;

    addr_t      wr_addr_q, wr_addr_d;
    logic [2:0] wr_q, wr_d;
    logic [7:0] ch_wd_q, ch_wd_d, fg_wd_q, fg_wd_d, bg_wd_q, bg_wd_d;
    logic       cpu_ack_q, cpu_ack_d, busy_q, busy_d, done_q, done_d;

    logic       cpu_grant, start_acc, range_empty, fill_wr, fill_last;
    addr_t      fill_addr;
    col_t       col_start_in, col_end_in;

`ifdef CHARRAM_COLRANGE_EN
    assign col_start_in = bus.fill_col_start;
    assign col_end_in   = bus.fill_col_end;
`else
    assign col_start_in = '0;
    assign col_end_in   = '1;
`endif

    // The CPU is never granted in the cycle its previous ack is visible, leaving every other slot to the fill.
    assign cpu_grant   = bus.cpu_req && !cpu_ack_q;
    assign start_acc   = (state_q == IDLE) && bus.fill_start;
    assign range_empty = (bus.fill_row_start > bus.fill_row_end) || (col_start_in > col_end_in);
    assign fill_wr     = !cpu_grant &&
                         ((start_acc && !range_empty) ||
                          ((state_q == FILL) && !bus.fill_abort && !last_wr_q));
    assign last_wr_d   = fill_wr && fill_last;

    charram_fill_addr u_fill_addr (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .load_i      (start_acc),
        .advance_i   (fill_wr),
        .row_start_i (bus.fill_row_start),
        .row_end_i   (bus.fill_row_end),
        .col_start_i (col_start_in),
        .col_end_i   (col_end_in),
        .addr_o      (fill_addr),
        .last_o      (fill_last)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            last_wr_q <= 1'b0;
            mask_q    <= '0;
            char_q    <= '0;
            fg_q      <= '0;
            bg_q      <= '0;
        end else begin
            state_q   <= state_d;
            last_wr_q <= last_wr_d;
            if (start_acc) begin
                mask_q <= bus.fill_mask;
                char_q <= bus.fill_char;
                fg_q   <= bus.fill_fg;
                bg_q   <= bus.fill_bg;
            end
        end
    end

    // The final fill write stays in FILL for its own cycle so done lands one cycle later.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_acc) state_d = range_empty ? DONE : FILL;
            FILL:    if (bus.fill_abort) state_d = IDLE;
                     else if (last_wr_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_addr_d = wr_addr_q;
        wr_d      = '0;
        ch_wd_d   = ch_wd_q;
        fg_wd_d   = fg_wd_q;
        bg_wd_d   = bg_wd_q;
        cpu_ack_d = cpu_grant;
        busy_d    = (state_d == FILL);
        done_d    = (state_d == DONE);
        if (cpu_grant) begin
            wr_addr_d = bus.cpu_addr;
            wr_d      = bus.cpu_sel;
            ch_wd_d   = bus.cpu_data;
            fg_wd_d   = bus.cpu_data;
            bg_wd_d   = bus.cpu_data;
        end else if (fill_wr) begin
            wr_addr_d = fill_addr;
            wr_d      = start_acc ? bus.fill_mask : mask_q;
            ch_wd_d   = start_acc ? bus.fill_char : char_q;
            fg_wd_d   = start_acc ? bus.fill_fg   : fg_q;
            bg_wd_d   = start_acc ? bus.fill_bg   : bg_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_addr_q <= '0;
            wr_q      <= '0;
            ch_wd_q   <= '0;
            fg_wd_q   <= '0;
            bg_wd_q   <= '0;
            cpu_ack_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            wr_addr_q <= wr_addr_d;
            wr_q      <= wr_d;
            ch_wd_q   <= ch_wd_d;
            fg_wd_q   <= fg_wd_d;
            bg_wd_q   <= bg_wd_d;
            cpu_ack_q <= cpu_ack_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.wr_addr     = wr_addr_q;
    assign bus.chram_wr    = wr_q[SEL_CHAR];
    assign bus.fgcol_wr    = wr_q[SEL_FG];
    assign bus.bgcol_wr    = wr_q[SEL_BG];
    assign bus.chram_wdata = ch_wd_q;
    assign bus.fgcol_wdata = fg_wd_q;
    assign bus.bgcol_wdata = bg_wd_q;
    assign bus.cpu_ack     = cpu_ack_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_charram_writer.sv
// Directed bench for charram_writer: CPU and fill writes are predicted into queues and popped as strobes appear.
module tb_charram_writer;
    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic [38:0] cpu_q[$];
    logic [38:0] fill_q[$];
    logic prev_ack = 1'b0;

    charram_writer_if bus();

    charram_writer dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [38:0] pack(input logic [11:0] a, input logic [2:0] s,
                                         input logic [7:0] c, input logic [7:0] f, input logic [7:0] b);
        return {a, s, s[0] ? c : 8'h00, s[1] ? f : 8'h00, s[2] ? b : 8'h00};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic any_wr();
        return bus.chram_wr | bus.fgcol_wr | bus.bgcol_wr;
    endfunction

    // Scoreboard: a write with cpu_ack belongs to the CPU queue, any other strobe to the fill queue.
    always @(negedge clk) begin
        logic [38:0] obs, exp;
        if (rst_n) begin
            obs = pack(bus.wr_addr, {bus.bgcol_wr, bus.fgcol_wr, bus.chram_wr},
                       bus.chram_wdata, bus.fgcol_wdata, bus.bgcol_wdata);
            if (bus.cpu_ack) begin
                check("ack_spacing", prev_ack, 1'b0);
                if (cpu_q.size() != 0) exp = cpu_q.pop_front();
                else exp = 'x;
                check("cpu_write", obs, exp);
            end else if (any_wr()) begin
                if (fill_q.size() != 0) exp = fill_q.pop_front();
                else exp = 'x;
                check("fill_write", obs, exp);
            end
            prev_ack = bus.cpu_ack;
        end else begin
            prev_ack = 1'b0;
        end
    end

    task automatic push_fill(input logic [5:0] rs, input logic [5:0] re, input logic [2:0] m,
                             input logic [7:0] c, input logic [7:0] f, input logic [7:0] b);
        for (int r = rs; r <= re; r++)
            for (int col = 0; col < 64; col++)
                fill_q.push_back(pack({r[5:0], col[5:0]}, m, c, f, b));
    endtask

    task automatic start_fill(input logic [5:0] rs, input logic [5:0] re, input logic [2:0] m,
                              input logic [7:0] c, input logic [7:0] f, input logic [7:0] b);
        bus.fill_row_start = rs;
        bus.fill_row_end   = re;
        bus.fill_mask      = m;
        bus.fill_char      = c;
        bus.fill_fg        = f;
        bus.fill_bg        = b;
        bus.fill_start     = 1'b1;
    endtask

    task automatic run_fill(input int limit, output int done_k, output int busy_n,
                            output int wr_n, output int done_n);
        done_k = -1; busy_n = 0; wr_n = 0; done_n = 0;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            if (k == 1) bus.fill_start = 1'b0;
            if (bus.busy) busy_n++;
            if (any_wr()) wr_n++;
            if (bus.done) begin
                done_n++;
                if (done_k < 0) done_k = k;
            end
            if (done_k >= 0 && k >= done_k + 2) break;
        end
    endtask

    task automatic cpu_write(input logic [2:0] sel, input logic [11:0] a, input logic [7:0] d);
        cpu_q.push_back(pack(a, sel, d, d, d));
        bus.cpu_req  = 1'b1;
        bus.cpu_sel  = sel;
        bus.cpu_addr = a;
        bus.cpu_data = d;
        @(negedge clk);
        check("cpu_ack_latency", bus.cpu_ack, 1'b1);
        bus.cpu_req = 1'b0;
        @(negedge clk);
        check("cpu_ack_pulse", bus.cpu_ack, 1'b0);
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_addr"},   bus.wr_addr, 12'h000);
        check({pfx, "_strobe"}, {bus.bgcol_wr, bus.fgcol_wr, bus.chram_wr}, 3'b000);
        check({pfx, "_wdata"},  {bus.chram_wdata, bus.fgcol_wdata, bus.bgcol_wdata}, 24'h0);
        check({pfx, "_ack"},    bus.cpu_ack, 1'b0);
        check({pfx, "_busy"},   bus.busy, 1'b0);
        check({pfx, "_done"},   bus.done, 1'b0);
    endtask

    initial begin
        int done_k, busy_n, wr_n, done_n, ack_n, k_ab, extra, dn;
        rst_n = 1'b0;
        bus.cpu_req = 1'b0; bus.cpu_sel = '0; bus.cpu_addr = '0; bus.cpu_data = '0;
        bus.fill_start = 1'b0; bus.fill_abort = 1'b0; bus.fill_mask = '0;
        bus.fill_row_start = '0; bus.fill_row_end = '0;
        bus.fill_char = '0; bus.fill_fg = '0; bus.fill_bg = '0;
`ifdef CHARRAM_COLRANGE_EN
        bus.fill_col_start = 6'd0;
        bus.fill_col_end   = 6'd63;
`endif
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // CPU writes while idle, including an empty select
        cpu_write(3'b010, 12'h0A5, 8'h3C);
        cpu_write(3'b000, 12'h123, 8'h99);
        cpu_write(3'b101, 12'hFFF, 8'hC3);

        // Two full rows, uncontended
        push_fill(6'd2, 6'd3, 3'b111, 8'h20, 8'hFF, 8'h00);
        start_fill(6'd2, 6'd3, 3'b111, 8'h20, 8'hFF, 8'h00);
        run_fill(300, done_k, busy_n, wr_n, done_n);
        check("full_done_cycle", done_k, 129);
        check("full_busy_cycles", busy_n, 128);
        check("full_writes", wr_n, 128);
        check("full_done_width", done_n, 1);
        check("full_queue_drained", fill_q.size(), 0);

        // One-row fill contended by ten back-to-back CPU writes
        @(negedge clk);
        push_fill(6'd7, 6'd7, 3'b101, 8'hA5, 8'hEE, 8'h5A);
        start_fill(6'd7, 6'd7, 3'b101, 8'hA5, 8'hEE, 8'h5A);
        cpu_q.push_back(pack(12'hF00, 3'b001, 8'h40, 8'h40, 8'h40));
        bus.cpu_req = 1'b1; bus.cpu_sel = 3'b001; bus.cpu_addr = 12'hF00; bus.cpu_data = 8'h40;
        done_k = -1; ack_n = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (k == 1) bus.fill_start = 1'b0;
            if (bus.cpu_ack) begin
                ack_n++;
                if (ack_n < 10) begin
                    bus.cpu_addr = 12'hF00 + 12'(ack_n);
                    bus.cpu_data = 8'h40 + 8'(ack_n);
                    cpu_q.push_back(pack(bus.cpu_addr, 3'b001, bus.cpu_data, bus.cpu_data, bus.cpu_data));
                end else begin
                    bus.cpu_req = 1'b0;
                end
            end
            if (bus.done) begin
                done_k = k;
                break;
            end
        end
        check("contend_done_cycle", done_k, 75);
        check("contend_cpu_acks", ack_n, 10);
        check("contend_fill_drained", fill_q.size(), 0);
        check("contend_cpu_drained", cpu_q.size(), 0);

        // Empty row range
        @(negedge clk);
        start_fill(6'd5, 6'd4, 3'b111, 8'h01, 8'h02, 8'h03);
        run_fill(10, done_k, busy_n, wr_n, done_n);
        check("empty_done_cycle", done_k, 1);
        check("empty_writes", wr_n, 0);
        check("empty_busy", busy_n, 0);
        check("empty_done_width", done_n, 1);

        // Abort after twenty fill writes, then restart
        @(negedge clk);
        for (int c = 0; c < 20; c++)
            fill_q.push_back(pack({6'd10, c[5:0]}, 3'b111, 8'h61, 8'h62, 8'h63));
        start_fill(6'd10, 6'd11, 3'b111, 8'h61, 8'h62, 8'h63);
        wr_n = 0; k_ab = -1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (k == 1) bus.fill_start = 1'b0;
            if (any_wr()) wr_n++;
            if (wr_n == 20) begin
                bus.fill_abort = 1'b1;
                k_ab = k;
                break;
            end
        end
        check("abort_at_write20", k_ab, 20);
        @(negedge clk);
        bus.fill_abort = 1'b0;
        check("abort_busy_low", bus.busy, 1'b0);
        extra = 0; dn = 0;
        repeat (5) begin
            if (any_wr()) extra++;
            if (bus.done) dn++;
            @(negedge clk);
        end
        check("abort_no_writes", extra, 0);
        check("abort_no_done", dn, 0);
        push_fill(6'd12, 6'd12, 3'b001, 8'h77, 8'h00, 8'h00);
        start_fill(6'd12, 6'd12, 3'b001, 8'h77, 8'h00, 8'h00);
        run_fill(100, done_k, busy_n, wr_n, done_n);
        check("restart_done_cycle", done_k, 65);
        check("restart_writes", wr_n, 64);

        // Zero mask still walks the row; starts during FILL and DONE are ignored
        @(negedge clk);
        start_fill(6'd20, 6'd20, 3'b000, 8'hAA, 8'hBB, 8'hCC);
        done_k = -1; wr_n = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            bus.fill_start = (k == 10);
            if (k == 10) begin
                bus.fill_row_start = 6'd0;
                bus.fill_row_end   = 6'd63;
            end
            if (any_wr()) wr_n++;
            if (bus.done) begin
                done_k = k;
                bus.fill_start = 1'b1;
                break;
            end
        end
        check("mask0_done_cycle", done_k, 65);
        check("mask0_no_strobes", wr_n, 0);
        @(negedge clk);
        bus.fill_start = 1'b0;
        check("start_in_done_busy", bus.busy, 1'b0);
        check("start_in_done_done", bus.done, 1'b0);

        // Asynchronous reset in the middle of a fill
        @(negedge clk);
        push_fill(6'd40, 6'd41, 3'b111, 8'h11, 8'h22, 8'h33);
        start_fill(6'd40, 6'd41, 3'b111, 8'h11, 8'h22, 8'h33);
        @(negedge clk);
        bus.fill_start = 1'b0;
        check("midfill_busy", bus.busy, 1'b1);
        repeat (30) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero("midreset");
        fill_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_busy", bus.busy, 1'b0);
        check("post_reset_strobe", any_wr(), 1'b0);
        push_fill(6'd30, 6'd30, 3'b010, 8'h00, 8'h5E, 8'h00);
        start_fill(6'd30, 6'd30, 3'b010, 8'h00, 8'h5E, 8'h00);
        run_fill(100, done_k, busy_n, wr_n, done_n);
        check("post_reset_fill_done", done_k, 65);
        check("post_reset_fill_busy", busy_n, 64);

        check("final_fill_queue", fill_q.size(), 0);
        check("final_cpu_queue", cpu_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
